pulse_rate_ctrl: RTL

- Control front-end for the random pulse generator.
- Decodes the rotary encoder (clk_in/dt_in lines, renamed enc_a/enc_b here) into a saturating 4-bit rate setting.
- Accepts direct rate loads from ui_in.
- Schedules pulse emission: req/ack handshake to the generator datapath at rate-dependent intervals, jittered by the generator's random byte.

---
 rtl/pulse_ctrl_pkg.sv | 24 ++
 rtl/enc_debounce.sv | 46 ++++
 rtl/pulse_rate_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pulse_ctrl_pkg.sv
// Shared types, constants and the interval-load arithmetic for the pulse rate controller.
package pulse_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StReq
    } sched_state_e;

    localparam int unsigned RATE_W = 4;
    localparam logic [RATE_W-1:0] RATE_MAX = 4'd15;

    // L = ((16 - rate) << unit_shift) + rnd; callers truncate to their counter width.
    function automatic logic [31:0] interval_load(
        input logic [RATE_W-1:0] rate,
        input logic [7:0]        rnd,
        input int unsigned       unit_shift
    );
        logic [4:0] span;
        span = 5'd16 - {1'b0, rate};
        return ({27'd0, span} << unit_shift) + {24'd0, rnd};
    endfunction

endpackage

// File: rtl/enc_debounce.sv
// Two-flop synchroniser followed by a stable-count debouncer; idles high like an encoder detent.
module enc_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_async,
    output logic filt
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            filt_q, filt_d;

    always_comb begin
        cnt_d  = cnt_q;
        filt_d = filt_q;
        if (sync_q[1] == filt_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntLast) begin
            // This is the DEBOUNCE_CYCLES-th consecutive differing sample.
            filt_d = sync_q[1];
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], raw_async};
            cnt_q  <= cnt_d;
            filt_q <= filt_d;
        end
    end

    assign filt = filt_q;

endmodule

// File: rtl/pulse_rate_ctrl.sv
// Rate front-end for the pulse generator: encoder decode, direct rate load and
// req/ack pulse scheduling at rate-dependent, rnd-jittered intervals.
module pulse_rate_ctrl
    import pulse_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000,
    parameter int unsigned UNIT_SHIFT      = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              enc_a,
    input  logic              enc_b,
    input  logic              rate_load,
    input  logic [RATE_W-1:0] rate_load_val,
    input  logic [7:0]        rnd,
    input  logic              pulse_ack,
    output logic              pulse_req,
    output logic [RATE_W-1:0] rate,
    output logic              step_evt
);

    logic a_filt, b_filt;
    logic a_prev_q;
    logic a_fall;

    logic [RATE_W-1:0] rate_q, rate_d;
    logic              step_evt_q, step_evt_d;

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  load_val;

    enc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_async(enc_a),
        .filt     (a_filt)
    );

    enc_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .raw_async(enc_b),
        .filt     (b_filt)
    );

    assign a_fall = a_prev_q & ~a_filt;

    // Direct load wins over a coincident encoder step, which is then dropped.
    always_comb begin
        rate_d     = rate_q;
        step_evt_d = 1'b0;
        if (rate_load) begin
            rate_d = rate_load_val;
        end else if (a_fall) begin
            if (b_filt) begin
                if (rate_q != RATE_MAX) begin
                    rate_d     = rate_q + RATE_W'(1);
                    step_evt_d = 1'b1;
                end
            end else begin
                if (rate_q != '0) begin
                    rate_d     = rate_q - RATE_W'(1);
                    step_evt_d = 1'b1;
                end
            end
        end
    end

    assign load_val = CNT_W'(interval_load(rate_q, rnd, UNIT_SHIFT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!ena) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    cnt_d   = load_val;
                    state_d = StCount;
                end
                StCount: begin
                    if (cnt_q == '0) begin
                        state_d = StReq;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                StReq: begin
                    if (pulse_ack) begin
                        cnt_d   = load_val;
                        state_d = StCount;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_prev_q   <= 1'b1;
            rate_q     <= '0;
            step_evt_q <= 1'b0;
            state_q    <= StIdle;
            cnt_q      <= '0;
        end else begin
            a_prev_q   <= a_filt;
            rate_q     <= rate_d;
            step_evt_q <= step_evt_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    assign pulse_req = (state_q == StReq);
    assign rate      = rate_q;
    assign step_evt  = step_evt_q;

endmodule
